ch_pkt_parser: RTL and testbench
================================

// Module: ch_pkt_parser
// PURPOSE
//  Upstream stage of knownCH. Consumes the byte stream of one received packet from the radio RX
//  buffer and decodes heartbeat (HB) and cluster-head announcement (CH) packets.
//  HB emits HB_reset/HB_CHlimit; CH emits fCH_ID/fCH_Hops/fCH_QValue with an en_KCH pulse.
//  Malformed or unknown packets are discarded and counted.
// PARAMETERS
//  MEM_WIDTH   8      RX byte width
//  WORD_WIDTH  16     decoded field width (two bytes, big-endian)
//  TYPE_HB     8'h01  type byte of heartbeat packet
//  TYPE_CH     8'h02  type byte of CH announcement packet
//  ERRCNT_W    8      width of error counter
// PORTS
//  clk         in   1           system clock, rising edge
//  nrst        in   1           asynchronous reset, active-high (1 = reset)
//  rx_valid    in   1           rx_data/rx_sop/rx_eop valid this cycle
//  rx_ready    out  1           parser accepts byte; transfer = rx_valid & rx_ready
//  rx_sop      in   1           first byte of packet
//  rx_eop      in   1           last byte of packet
//  rx_data     in   MEM_WIDTH   packet byte
//  HB_reset    out  1           1-cycle pulse: valid HB packet decoded
//  HB_CHlimit  out  WORD_WIDTH  CH limit from last valid HB
//  fCH_ID      out  WORD_WIDTH  CH node ID from last valid CH packet
//  fCH_Hops    out  WORD_WIDTH  received hop count + 1, saturating
//  fCH_QValue  out  WORD_WIDTH  CH Q-value (Q2.14 fixed point, passed unchanged)
//  en_KCH      out  1           1-cycle pulse: new CH fields valid
//  pkt_err     out  1           1-cycle pulse: packet discarded as malformed
//  err_count   out  ERRCNT_W    saturating count of pkt_err pulses
// BEHAVIOUR
//  Formats (bytes in order): HB = type, src_hi, src_lo, lim_hi, lim_lo (5 bytes).
//   CH = type, id_hi, id_lo, hop_hi, hop_lo, q_hi, q_lo (7 bytes). Hi byte first.
//  Reset: rx_ready=1, HB_reset=0, en_KCH=0, pkt_err=0, HB_CHlimit=0, fCH_ID=0,
//   fCH_Hops=16'hFFFF, fCH_QValue=0, err_count=0, state=IDLE, byte counter=0.
//  States: IDLE -> (sop, type HB/CH) COLLECT; (sop, other type) DROP; non-sop byte ignored.
//   COLLECT: bytes go to shadow regs; counter increments per accepted byte.
//   eop on exact last byte -> EMIT. eop early -> IDLE + pkt_err.
//   Last byte without eop -> DROP + pkt_err; no commit.
//   DROP: swallow bytes until eop, then IDLE; no further pkt_err for that packet.
//   EMIT (1 cycle): copy shadow to outputs, pulse HB_reset or en_KCH, rx_ready=0; -> IDLE.
//  Latency: last byte accepted in cycle N -> outputs updated and pulse high in N+1;
//   rx_ready low only in N+1, high again in N+2.
//  Outputs change only in EMIT; partial or discarded packets never disturb held values.
//  HB does not alter fCH_* and CH does not alter HB_CHlimit; src ID of HB is parsed and discarded.
//  Hops: fCH_Hops = (hop==16'hFFFF) ? 16'hFFFF : hop+1 (no wrap).
//  sop during COLLECT/DROP: abort current packet (pkt_err if in COLLECT), restart with this byte
//   as type byte. Byte with sop&eop and valid type = too short -> pkt_err.
//  rx_valid=0 bubbles anywhere: state held, no timeout.
//  err_count saturates at all-ones. Unknown type is not an error (silent DROP).
//  nrst mid-packet: immediate return to reset values; partial packet lost, no pulse.
// TESTING
//  1 HB 01 00 05 00 03 back-to-back -> cycle after eop: HB_reset=1 one cycle, HB_CHlimit=3.
//  2 CH 02 00 17 00 01 30 00 -> en_KCH pulse, fCH_ID=23, fCH_Hops=2, fCH_QValue=16'h3000;
//    rx_ready=0 only in pulse cycle; repeat with rx_valid gaps -> same result.
//  3 CH with hops 16'hFFFF -> fCH_Hops=16'hFFFF; hops 16'hFFFE -> 16'hFFFF.
//  4 CH truncated (eop on byte 5) -> pkt_err=1, err_count=1, no en_KCH, fCH_* unchanged;
//    CH of 8 bytes -> pkt_err once, DROP to eop, no en_KCH.
//  5 type 8'h07 packet -> no pulses, err_count unchanged; new sop mid-CH aborts,
//    following valid CH 02 00 0C 00 00 40 00 -> fCH_ID=12, fCH_Hops=1, fCH_QValue=16'h4000.
//  6 nrst=1 asserted mid-CH, released, then valid HB -> all outputs at reset values during
//    reset, err_count=0, HB decoded normally afterwards.

Source files
------------

// File: rtl/ch_pkt_parser.sv
// ch_pkt_parser
//   Front end of knownCH. Takes the byte stream of one received packet from
//   the radio RX buffer and decodes two packet types:
//     HB (heartbeat) : type, src_hi, src_lo, lim_hi, lim_lo        (5 bytes)
//     CH (announce)  : type, id_hi, id_lo, hop_hi, hop_lo, q_hi, q_lo (7 bytes)
//   Multi-byte fields arrive high byte first. Malformed packets are dropped,
//   flagged with pkt_err and counted. Unknown packet types are dropped silently.
//
// Ports
//   clk          in   rising-edge clock
//   nrst         in   asynchronous reset, active-high (1 = reset)
//   rx_valid     in   rx_data / rx_sop / rx_eop valid
//   rx_ready     out  parser can take a byte (low only in the emit cycle)
//   rx_sop       in   first byte of a packet
//   rx_eop       in   last byte of a packet
//   rx_data      in   packet byte
//   HB_reset     out  1-cycle pulse: valid HB decoded
//   HB_CHlimit   out  CH limit from the last valid HB
//   fCH_ID       out  CH node ID from the last valid CH
//   fCH_Hops     out  received hop count + 1, saturating at all-ones
//   fCH_QValue   out  CH Q-value (Q2.14), passed through
//   en_KCH       out  1-cycle pulse: new fCH_* values
//   pkt_err      out  1-cycle pulse: packet discarded as malformed
//   err_count    out  saturating count of pkt_err pulses
//   o_dbg_state  out  current FSM state (IDLE=0, COLLECT=1, DROP=2, EMIT=3)
//
// Handshake: a byte transfers on a rising edge where rx_valid & rx_ready are
// both high. rx_ready depends only on the FSM state, never on rx_valid, so an
// upstream source may hold rx_valid high while it waits.

module ch_pkt_parser #(
   parameter int                   MEM_WIDTH  = 8,
   parameter int                   WORD_WIDTH = 16,
   parameter logic [MEM_WIDTH-1:0] TYPE_HB    = 8'h01,
   parameter logic [MEM_WIDTH-1:0] TYPE_CH    = 8'h02,
   parameter int                   ERRCNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  rx_sop,
   input  logic                  rx_eop,
   input  logic [MEM_WIDTH-1:0]  rx_data,
   output logic                  HB_reset,
   output logic [WORD_WIDTH-1:0] HB_CHlimit,
   output logic [WORD_WIDTH-1:0] fCH_ID,
   output logic [WORD_WIDTH-1:0] fCH_Hops,
   output logic [WORD_WIDTH-1:0] fCH_QValue,
   output logic                  en_KCH,
   output logic                  pkt_err,
   output logic [ERRCNT_W-1:0]   err_count,
   output logic [1:0]            o_dbg_state
);

   // Shadow store for payload bytes 1..5; the final byte is taken live.
   localparam int SHW = 5 * MEM_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DROP    = 2'd2,
      S_EMIT    = 2'd3
   } state_t;

   state_t                r_state, w_next_state;
   logic [2:0]            r_cnt, w_cnt_next;
   logic                  r_is_ch, w_is_ch_next;
   logic [SHW-1:0]        r_shift;
   logic [WORD_WIDTH-1:0] r_hb_limit, r_ch_id, r_ch_hops, r_ch_q;
   logic                  r_hb_reset, r_en_kch, r_pkt_err;
   logic [ERRCNT_W-1:0]   r_err_count;

   logic                  w_xfer, w_type_hb, w_type_ch, w_at_last;
   logic                  w_shift_en, w_commit, w_err;
   logic [WORD_WIDTH-1:0] w_hop, w_hop_next;

   assign rx_ready    = (r_state != S_EMIT);
   assign w_xfer      = rx_valid & rx_ready;
   assign w_type_hb   = (rx_data == TYPE_HB);
   assign w_type_ch   = (rx_data == TYPE_CH);
   // r_cnt is the index of the byte about to be accepted (type byte = 0).
   assign w_at_last   = (r_cnt == (r_is_ch ? 3'd6 : 3'd4));
   // After five shifts of a CH packet: {id_hi, id_lo, hop_hi, hop_lo, q_hi}.
   assign w_hop       = r_shift[3*MEM_WIDTH-1:MEM_WIDTH];
   assign w_hop_next  = (&w_hop) ? w_hop : w_hop + WORD_WIDTH'(1);

   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      w_is_ch_next = r_is_ch;
      w_shift_en   = 1'b0;
      w_commit     = 1'b0;
      w_err        = 1'b0;
      if (w_xfer && rx_sop) begin
         // A sop byte always starts a new packet, abandoning any packet in
         // progress; only a packet still being collected counts as an error.
         if (r_state == S_COLLECT) w_err = 1'b1;
         if (w_type_hb || w_type_ch) begin
            if (rx_eop) begin
               w_err        = 1'b1;
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_COLLECT;
               w_cnt_next   = 3'd1;
               w_is_ch_next = w_type_ch;
            end
         end else begin
            w_next_state = rx_eop ? S_IDLE : S_DROP;
         end
      end else begin
         case (r_state)
            S_COLLECT: begin
               if (w_xfer) begin
                  if (w_at_last) begin
                     w_cnt_next = 3'd0;
                     if (rx_eop) begin
                        w_commit     = 1'b1;
                        w_next_state = S_EMIT;
                     end else begin
                        w_err        = 1'b1;
                        w_next_state = S_DROP;
                     end
                  end else begin
                     w_shift_en = 1'b1;
                     if (rx_eop) begin
                        w_err        = 1'b1;
                        w_next_state = S_IDLE;
                        w_cnt_next   = 3'd0;
                     end else begin
                        w_cnt_next = r_cnt + 3'd1;
                     end
                  end
               end
            end
            S_DROP: begin
               if (w_xfer && rx_eop) w_next_state = S_IDLE;
            end
            S_EMIT: w_next_state = S_IDLE;
            default: ;
         endcase
      end
   end

   // Output registers load on the edge that accepts the final byte, so the
   // new values and the pulse are visible throughout the EMIT cycle.
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_is_ch     <= 1'b0;
         r_shift     <= '0;
         r_hb_limit  <= '0;
         r_ch_id     <= '0;
         r_ch_hops   <= '1;
         r_ch_q      <= '0;
         r_hb_reset  <= 1'b0;
         r_en_kch    <= 1'b0;
         r_pkt_err   <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state    <= w_next_state;
         r_cnt      <= w_cnt_next;
         r_is_ch    <= w_is_ch_next;
         r_hb_reset <= 1'b0;
         r_en_kch   <= 1'b0;
         r_pkt_err  <= w_err;
         if (w_shift_en) r_shift <= {r_shift[SHW-MEM_WIDTH-1:0], rx_data};
         if (w_commit) begin
            if (r_is_ch) begin
               r_ch_id   <= r_shift[SHW-1:3*MEM_WIDTH];
               r_ch_hops <= w_hop_next;
               r_ch_q    <= {r_shift[MEM_WIDTH-1:0], rx_data};
               r_en_kch  <= 1'b1;
            end else begin
               r_hb_limit <= {r_shift[MEM_WIDTH-1:0], rx_data};
               r_hb_reset <= 1'b1;
            end
         end
         if (w_err && (r_err_count != '1)) r_err_count <= r_err_count + ERRCNT_W'(1);
      end
   end

   assign HB_reset    = r_hb_reset;
   assign HB_CHlimit  = r_hb_limit;
   assign fCH_ID      = r_ch_id;
   assign fCH_Hops    = r_ch_hops;
   assign fCH_QValue  = r_ch_q;
   assign en_KCH      = r_en_kch;
   assign pkt_err     = r_pkt_err;
   assign err_count   = r_err_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ch_pkt_parser.sv
// Testbench for ch_pkt_parser: directed packets from the block description
// followed by randomized packet streams, checked by a packet-level reference
// model feeding an expected-event queue that a separate monitor drains.

module tb_ch_pkt_parser;

  localparam int EW = 2 + 16*4 + 8;  // kind, limit, id, hops, q, err_count

  logic        clk = 1'b0;
  logic        nrst;
  logic        rx_valid, rx_ready, rx_sop, rx_eop;
  logic [7:0]  rx_data;
  logic        HB_reset, en_KCH, pkt_err;
  logic [15:0] HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue;
  logic [7:0]  err_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ch_pkt_parser dut (
    .clk(clk), .nrst(nrst), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_data(rx_data),
    .HB_reset(HB_reset), .HB_CHlimit(HB_CHlimit), .fCH_ID(fCH_ID),
    .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue), .en_KCH(en_KCH),
    .pkt_err(pkt_err), .err_count(err_count), .o_dbg_state(dbg_state)
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // reference model: values the outputs should hold after each queued event
  logic [15:0] mdl_lim, mdl_id, mdl_hops, mdl_q;
  logic [7:0]  mdl_err;
  // monitor copy: values that should be on the outputs right now
  logic [15:0] m_lim, m_id, m_hops, m_q;
  logic [7:0]  m_err;

  logic [7:0] fb[0:11];

  task automatic model_reset();
    mdl_lim = 16'h0; mdl_id = 16'h0; mdl_hops = 16'hFFFF; mdl_q = 16'h0; mdl_err = 8'h0;
    m_lim = 16'h0;   m_id = 16'h0;   m_hops = 16'hFFFF;   m_q = 16'h0;   m_err = 8'h0;
  endtask

  // One frame = bytes fb[0..n-1], sop on the first, eop on the last if
  // with_eop; otherwise the frame is cut short by the next frame's sop.
  task automatic model_frame(input int n, input bit with_eop);
    int len;
    logic [15:0] hop;
    len = (fb[0] == 8'h01) ? 5 : (fb[0] == 8'h02) ? 7 : 0;
    if (len == 0) return;                 // unknown type: silently ignored
    if (with_eop && n == len) begin
      if (len == 5) begin
        mdl_lim = {fb[3], fb[4]};
        exp_q.push_back({2'd0, mdl_lim, mdl_id, mdl_hops, mdl_q, mdl_err});
      end else begin
        mdl_id   = {fb[1], fb[2]};
        hop      = {fb[3], fb[4]};
        mdl_hops = (hop == 16'hFFFF) ? 16'hFFFF : hop + 16'd1;
        mdl_q    = {fb[5], fb[6]};
        exp_q.push_back({2'd1, mdl_lim, mdl_id, mdl_hops, mdl_q, mdl_err});
      end
    end else begin
      // too short, too long, or aborted: exactly one error per packet
      if (mdl_err != 8'hFF) mdl_err = mdl_err + 8'd1;
      exp_q.push_back({2'd2, mdl_lim, mdl_id, mdl_hops, mdl_q, mdl_err});
    end
  endtask

  // ---- driver tasks (all start and end on a falling edge) ----
  task automatic send_byte(input logic [7:0] d, input bit s, input bit e, input bit gaps);
    bit acc, done;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_valid = 1'b1; rx_data = d; rx_sop = s; rx_eop = e;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      acc = rx_ready;
      @(negedge clk);
      if (acc) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL handshake: byte %h not accepted, rx_ready=%b want 1", d, rx_ready);
    end
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic set_fb(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) fb[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic send_frame(input int n, input bit with_eop, input bit gaps);
    model_frame(n, with_eop);
    for (int i = 0; i < n; i++) send_byte(fb[i], i == 0, with_eop && (i == n-1), gaps);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, want 0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset(input string name);
    logic [76:0] got, want;
    got  = {rx_ready, HB_reset, en_KCH, pkt_err, HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue, err_count};
    want = {1'b1, 3'b000, 16'h0, 16'h0, 16'hFFFF, 16'h0, 8'h0};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---- monitor ----
  always @(negedge clk) begin : monitor
    logic [2:0]    p, ep;
    logic [EW-1:0] e;
    logic [71:0]   got_f;
    if (mon_en && !nrst) begin
      p     = {HB_reset, en_KCH, pkt_err};
      got_f = {HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue, err_count};
      checks++;
      if (p != 3'b000) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got {hb,kch,err}=%b want none", p);
        end else begin
          e = exp_q.pop_front();
          case (e[EW-1 -: 2])
            2'd0:    ep = 3'b100;
            2'd1:    ep = 3'b010;
            default: ep = 3'b001;
          endcase
          if (p !== ep) begin
            errors++;
            $display("FAIL pulse_kind: got {hb,kch,err}=%b want %b", p, ep);
          end
          checks++;
          if (got_f !== e[71:0]) begin
            errors++;
            $display("FAIL event_fields: got %h want %h", got_f, e[71:0]);
          end
          checks++;
          if (rx_ready !== ep[0]) begin
            errors++;
            $display("FAIL ready_in_pulse: got %b want %b", rx_ready, ep[0]);
          end
          {m_lim, m_id, m_hops, m_q, m_err} = e[71:0];
        end
      end else begin
        if ({rx_ready, got_f} !== {1'b1, m_lim, m_id, m_hops, m_q, m_err}) begin
          errors++;
          $display("FAIL held: got rdy=%b %h want rdy=1 %h", rx_ready, got_f,
                   {m_lim, m_id, m_hops, m_q, m_err});
        end
      end
    end
  end

  // ---- stimulus ----
  initial begin
    bit prev_eop;
    int n, len, sel;
    bit e, g;
    nrst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset_init");
    nrst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // HB back-to-back
    set_fb(96'h01_00_05_00_03, 5);             send_frame(5, 1, 0);
    // CH, then the same CH with bubbles
    set_fb(96'h02_00_17_00_01_30_00, 7);       send_frame(7, 1, 0);
    set_fb(96'h02_00_17_00_01_30_00, 7);       send_frame(7, 1, 1);
    // hop saturation boundaries
    set_fb(96'h02_00_21_FF_FF_12_34, 7);       send_frame(7, 1, 0);
    set_fb(96'h02_00_22_FF_FE_12_35, 7);       send_frame(7, 1, 1);
    // truncated CH, over-long CH
    set_fb(96'h02_00_11_00_04, 5);             send_frame(5, 1, 0);
    set_fb(96'h02_00_11_00_04_12_34_56, 8);    send_frame(8, 1, 0);
    // unknown type, stray non-sop bytes, sop&eop HB
    set_fb(96'h07_AA_BB_CC, 4);                send_frame(4, 1, 0);
    send_byte(8'h02, 0, 0, 0);
    send_byte(8'h01, 0, 1, 0);
    set_fb(96'h01, 1);                         send_frame(1, 1, 0);
    // CH aborted by a new sop, then a valid CH
    set_fb(96'h02_00_33, 3);                   send_frame(3, 0, 0);
    set_fb(96'h02_00_0C_00_00_40_00, 7);       send_frame(7, 1, 0);
    wait_drain("drain_directed");

    // reset in the middle of a CH packet
    send_byte(8'h02, 1, 0, 0);
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'h44, 0, 0, 0);
    mon_en = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
    check_reset("reset_mid_pkt");
    model_reset();
    @(negedge clk);
    check_reset("reset_held");
    nrst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    set_fb(96'h01_00_09_00_07, 5);             send_frame(5, 1, 0);
    wait_drain("drain_after_reset");

    // randomized packet stream
    prev_eop = 1'b1;
    for (int f = 0; f < 60; f++) begin
      sel = $urandom_range(0, 9);
      fb[0] = (sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom_range(3, 255));
      len = (fb[0] == 8'h01) ? 5 : 7;
      n = ($urandom_range(0, 9) < 6) ? len : $urandom_range(1, 10);
      if (!prev_eop && n < 2) n = 2;
      e = ($urandom_range(0, 99) < 85) || (f == 59);
      g = $urandom_range(0, 1);
      for (int i = 1; i < n; i++) fb[i] = 8'($urandom_range(0, 255));
      send_frame(n, e, g);
      prev_eop = e;
      if (e && $urandom_range(0, 4) == 0)
        send_byte(8'($urandom_range(0, 255)), 0, $urandom_range(0, 1), g);
    end
    wait_drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
